vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_ACTIVE, default 640: required active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: required active lines per frame.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 vga_clk  in  1  pixel clock from the VGA transmitter, clk/2, treated as data.
REQ-007 vga_hs, vga_vs  in  1 each  sync, active-low.
REQ-008 vga_blank_n  in  1  high during the active pixel region.
REQ-009 vga_r, vga_g, vga_b  in  8 each  pixel colour.
REQ-010 pixel_valid  out  1  one-clk pulse per captured active pixel, only while locked.
REQ-011 pixelX, pixelY  out  11 each  coordinate of the captured pixel.
REQ-012 rgb  out  24  {r,g,b} of the captured pixel.
REQ-013 frame_start  out  1  one-clk pulse on every detected vs falling edge.
REQ-014 locked  out  1  high in LOCKED state.
REQ-015 lock_err  out  1  one-clk pulse when LOCKED is lost.
REQ-016 frame_count  out  16  frames completed while locked; wraps.

Function
REQ-017 All vga_* inputs SHALL be registered once (stage q), then vga_clk, hs, vs and blank_n once more (stage qq).
REQ-018 pix_stb = vga_clk_q & ~vga_clk_qq; all capture happens only on pix_stb, using stage-q values.
REQ-019 Latency: pixel_valid, pixelX, pixelY and rgb update 2 clk after the vga_clk rising edge at the pins, then hold until the next capture.
REQ-020 On pix_stb with blank_n=1: xcnt increments, saturating at 2047; the pre-increment value is the captured pixelX.
REQ-021 On pix_stb where blank_n falls: line_len_ok &= (xcnt==H_ACTIVE); xcnt is cleared; ycnt increments, saturating at 2047.
REQ-022 On pix_stb where vs falls: frame end. The FSM evaluates v_ok=(ycnt==V_ACTIVE) and line_len_ok; ycnt and xcnt clear; line_len_ok sets to 1; frame_start pulses.
REQ-023 FSM states: SEARCH, MEASURE, LOCKED.
REQ-024 SEARCH -> MEASURE on the first vs falling edge; no checks are made on that edge.
REQ-025 MEASURE -> LOCKED at frame end if v_ok and line_len_ok; otherwise MEASURE -> SEARCH.
REQ-026 LOCKED stays LOCKED at frame end if both checks pass, and frame_count increments.
REQ-027 LOCKED -> SEARCH at frame end on any check failure; lock_err pulses in the same clk as frame_start.
REQ-028 pixel_valid SHALL be asserted only in LOCKED; pixels of the frame that completes lock are not emitted.
REQ-029 vs falling and blank_n falling on the same pix_stb: the line closes first (REQ-021), then the frame end is evaluated with the updated ycnt.
REQ-030 hs is monitored only for edge detection; it does not affect counters.

Reset
REQ-031 Reset SHALL force SEARCH and clear xcnt and ycnt; line_len_ok = 1.
REQ-032 Reset SHALL drive pixel_valid, frame_start, locked, lock_err, frame_count, pixelX, pixelY and rgb to 0.
REQ-033 Reset SHALL clear all q/qq registers to 0, except sync q/qq registers, which reset to 1 (inactive).
REQ-034 Reset asserted mid-frame SHALL drop locked in the next clk; relock requires a full SEARCH -> MEASURE -> LOCKED sequence.

Structure
REQ-035 The FSM state enum and the default H_ACTIVE/V_ACTIVE constants SHALL live in the shared game package.
REQ-036 One sub-module, vga_edge_detect, SHALL hold the q/qq registers and produce pix_stb plus the vs and blank_n falling strobes.

Verification
REQ-037 Bench: drive the game VGA transmitter at 640x480 for 3 frames. Required: locked rises at the 2nd vs fall after reset; pixel_valid count is 307200 in frame 3; frame_count=1 after frame 3.
REQ-038 Bench: in a locked stream, set rgb=24'hFF0000 at pixel (639,479). Required: pixel_valid with pixelX=639, pixelY=479, rgb=FF0000 exactly 2 clk after that vga_clk edge.
REQ-039 Bench: while locked, shorten one line to 639 active pixels. Required: at that frame end, lock_err pulses coincident with frame_start, locked falls, and no pixel_valid appears until relock.
REQ-040 Bench: send 481 active lines during MEASURE. Required: return to SEARCH, locked stays 0, lock_err stays 0.
REQ-041 Bench: assert reset for 1 clk at pixel (100,200) while locked. Required: next clk locked=0 and pixelX=pixelY=0; relock occurs after 2 further vs falls.
REQ-042 Bench: hold blank_n high for 3000 pixels. Required: xcnt saturates at 2047, and the next vs fall fails the check.

Source files
------------

// File: rtl/vga_sync_decoder_pkg.sv
// Shared types and constants for the VGA sync decoder: lock FSM states,
// counter widths, colour payload and a saturating counter helper.
package vga_sync_decoder_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned CNT_W        = 11;
    localparam int unsigned FCNT_W       = 16;
    localparam int unsigned COLOR_W      = 8;
    localparam int unsigned RGB_W        = 3 * COLOR_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Two-stage input synchroniser for the VGA pins; derives the pixel strobe and
// the per-pixel falling strobes of vs, hs and blank_n.
module vga_edge_detect
    import vga_sync_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_vga_clk,
    input  logic               i_vga_hs,
    input  logic               i_vga_vs,
    input  logic               i_vga_blank_n,
    input  rgb_t               i_rgb,
    output logic               o_pix_stb_c,
    output logic               o_vs_fall_c,
    output logic               o_hs_fall_c,
    output logic               o_blank_fall_c,
    output logic               o_blank_q,
    output rgb_t               o_rgb_q
);

    logic r_clk_q;
    logic r_clk_qq;
    logic r_hs_q;
    logic r_hs_qq;
    logic r_vs_q;
    logic r_vs_qq;
    logic r_blank_q;
    logic r_blank_qq;
    rgb_t r_rgb_q;

    // Syncs idle high so a reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_q    <= 1'b0;
            r_clk_qq   <= 1'b0;
            r_hs_q     <= 1'b1;
            r_hs_qq    <= 1'b1;
            r_vs_q     <= 1'b1;
            r_vs_qq    <= 1'b1;
            r_blank_q  <= 1'b0;
            r_blank_qq <= 1'b0;
            r_rgb_q    <= '0;
        end else begin
            r_clk_q    <= i_vga_clk;
            r_clk_qq   <= r_clk_q;
            r_hs_q     <= i_vga_hs;
            r_hs_qq    <= r_hs_q;
            r_vs_q     <= i_vga_vs;
            r_vs_qq    <= r_vs_q;
            r_blank_q  <= i_vga_blank_n;
            r_blank_qq <= r_blank_q;
            r_rgb_q    <= i_rgb;
        end
    end

    // With vga_clk = clk/2, the qq stage holds the previous pixel on a strobe.
    assign o_pix_stb_c    = r_clk_q & ~r_clk_qq;
    assign o_vs_fall_c    = o_pix_stb_c & ~r_vs_q & r_vs_qq;
    assign o_hs_fall_c    = o_pix_stb_c & ~r_hs_q & r_hs_qq;
    assign o_blank_fall_c = o_pix_stb_c & ~r_blank_q & r_blank_qq;
    assign o_blank_q      = r_blank_q;
    assign o_rgb_q        = r_rgb_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a VGA transmitter's pins and
// tracks whether the stream matches the expected active geometry.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vga_clk,
    input  logic                 vga_hs,
    input  logic                 vga_vs,
    input  logic                 vga_blank_n,
    input  logic [COLOR_W-1:0]   vga_r,
    input  logic [COLOR_W-1:0]   vga_g,
    input  logic [COLOR_W-1:0]   vga_b,
    output logic                 pixel_valid,
    output logic [CNT_W-1:0]     pixelX,
    output logic [CNT_W-1:0]     pixelY,
    output logic [RGB_W-1:0]     rgb,
    output logic                 frame_start,
    output logic                 locked,
    output logic                 lock_err,
    output logic [FCNT_W-1:0]    frame_count
);

    logic        w_pix_stb;
    logic        w_vs_fall;
    logic        w_unused_hs_fall;
    logic        w_blank_fall;
    logic        w_blank_q;
    rgb_t        w_rgb_q;
    rgb_t        w_rgb_in;

    assign w_rgb_in = '{r: vga_r, g: vga_g, b: vga_b};

    vga_edge_detect u_edge (
        .clk            (clk),
        .reset          (reset),
        .i_vga_clk      (vga_clk),
        .i_vga_hs       (vga_hs),
        .i_vga_vs       (vga_vs),
        .i_vga_blank_n  (vga_blank_n),
        .i_rgb          (w_rgb_in),
        .o_pix_stb_c    (w_pix_stb),
        .o_vs_fall_c    (w_vs_fall),
        .o_hs_fall_c    (w_unused_hs_fall),
        .o_blank_fall_c (w_blank_fall),
        .o_blank_q      (w_blank_q),
        .o_rgb_q        (w_rgb_q)
    );

    sync_state_e       r_state;
    sync_state_e       w_next_state;
    logic [CNT_W-1:0]  r_xcnt;
    logic [CNT_W-1:0]  r_ycnt;
    logic              r_line_len_ok;

    logic [CNT_W-1:0]  w_ycnt_closed;
    logic              w_len_ok_closed;
    logic              w_frame_ok;
    logic              w_lock_lost;
    logic              w_count_frame;
    logic              w_capture;

    logic              r_pixel_valid;
    logic [CNT_W-1:0]  r_pixel_x;
    logic [CNT_W-1:0]  r_pixel_y;
    rgb_t              r_rgb;
    logic              r_frame_start;
    logic              r_locked;
    logic              r_lock_err;
    logic [FCNT_W-1:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A line closing on the same strobe as vs is folded in before judging the frame.
    always_comb begin
        w_next_state    = r_state;
        w_lock_lost     = 1'b0;
        w_count_frame   = 1'b0;
        w_ycnt_closed   = w_blank_fall ? sat_inc(r_ycnt) : r_ycnt;
        w_len_ok_closed = r_line_len_ok &
                          (~w_blank_fall | (r_xcnt == CNT_W'(H_ACTIVE)));
        w_frame_ok      = w_len_ok_closed & (w_ycnt_closed == CNT_W'(V_ACTIVE));
        if (w_vs_fall) begin
            unique case (r_state)
                ST_SEARCH: begin
                    w_next_state = ST_MEASURE;
                end
                ST_MEASURE: begin
                    w_next_state = w_frame_ok ? ST_LOCKED : ST_SEARCH;
                end
                ST_LOCKED: begin
                    if (w_frame_ok) begin
                        w_count_frame = 1'b1;
                    end else begin
                        w_next_state = ST_SEARCH;
                        w_lock_lost  = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_SEARCH;
                end
            endcase
        end
    end

    // Geometry counters: xcnt counts active pixels, ycnt counts closed lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xcnt        <= '0;
            r_ycnt        <= '0;
            r_line_len_ok <= 1'b1;
        end else if (w_vs_fall) begin
            r_xcnt        <= '0;
            r_ycnt        <= '0;
            r_line_len_ok <= 1'b1;
        end else if (w_blank_fall) begin
            r_xcnt        <= '0;
            r_ycnt        <= sat_inc(r_ycnt);
            r_line_len_ok <= w_len_ok_closed;
        end else if (w_pix_stb && w_blank_q) begin
            r_xcnt        <= sat_inc(r_xcnt);
        end
    end

    assign w_capture = w_pix_stb & w_blank_q & (r_state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_valid <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_lock_err    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_pixel_valid <= w_capture;
            r_frame_start <= w_vs_fall;
            r_lock_err    <= w_lock_lost;
            r_locked      <= (w_next_state == ST_LOCKED);
            if (w_count_frame) begin
                r_frame_count <= r_frame_count + FCNT_W'(1);
            end
            if (w_capture) begin
                r_pixel_x <= r_xcnt;
                r_pixel_y <= r_ycnt;
                r_rgb     <= w_rgb_q;
            end
        end
    end

    assign pixel_valid = r_pixel_valid;
    assign pixelX      = r_pixel_x;
    assign pixelY      = r_pixel_y;
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign lock_err    = r_lock_err;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised frame-level bench for vga_sync_decoder on a reduced 16x8 raster,
// scored against a frame/pixel reference model.
module tb_vga_sync_decoder;

    localparam int unsigned H   = 16;
    localparam int unsigned V   = 8;
    localparam int unsigned HBL = 6;
    localparam int unsigned VBL = 3;
    localparam int unsigned LW  = H + HBL;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        pixel_valid;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [23:0] rgb;
    logic        frame_start;
    logic        locked;
    logic        lock_err;
    logic [15:0] frame_count;

    vga_sync_decoder #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk         (clk),
        .reset       (reset),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .pixel_valid (pixel_valid),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .rgb         (rgb),
        .frame_start (frame_start),
        .locked      (locked),
        .lock_err    (lock_err),
        .frame_count (frame_count)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        int unsigned due;
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] c;
    } pix_exp_t;

    typedef struct packed {
        int unsigned due;
        logic        err;
        logic        lk;
        logic [15:0] fc;
    } frm_exp_t;

    pix_exp_t    pix_q[$];
    frm_exp_t    frm_q[$];
    int          lens[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int          pix_cnt = 0;
    int          last_frame_pix = 0;
    int          m_phase = 0;   // 0 search, 1 measure, 2 locked
    int          m_fc = 0;
    bit          rst_armed = 1'b0;
    int          rst_x = 0;
    int          rst_y = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        bit       exp_pv;
        bit       exp_fs;
        pix_exp_t pe;
        frm_exp_t fe;
        exp_pv = (pix_q.size() > 0) && (pix_q[0].due == cyc);
        check("pixel_valid", 128'(pixel_valid), 128'(exp_pv));
        if (pixel_valid === 1'b1) pix_cnt++;
        if (exp_pv) begin
            pe = pix_q.pop_front();
            check("pixel_data", 128'({pixelX, pixelY, rgb}), 128'({pe.x, pe.y, pe.c}));
        end
        exp_fs = (frm_q.size() > 0) && (frm_q[0].due == cyc);
        check("frame_start", 128'(frame_start), 128'(exp_fs));
        if (exp_fs) begin
            fe = frm_q.pop_front();
            check("lock_err", 128'(lock_err), 128'(fe.err));
            check("locked", 128'(locked), 128'(fe.lk));
            check("frame_count", 128'(frame_count), 128'(fe.fc));
            last_frame_pix = pix_cnt;
            pix_cnt = 0;
        end else begin
            check("lock_err_idle", 128'(lock_err), 128'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    // Frame-end rules: first edge only arms, then both checks must pass.
    task automatic model_frame_end(input bit ok);
        frm_exp_t fe;
        bit err;
        err = 1'b0;
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) m_phase = ok ? 2 : 0;
        else if (ok) m_fc++;
        else begin
            m_phase = 0;
            err = 1'b1;
        end
        fe = '{due: cyc + 2, err: err, lk: (m_phase == 2), fc: 16'(m_fc)};
        frm_q.push_back(fe);
    endtask

    task automatic drive_pixel(input logic blank, input logic hs, input logic vs,
                               input logic [23:0] c, input int x, input int y,
                               input bit vs_fall, input bit ok);
        bit rst_now;
        pix_exp_t pe;
        tick();
        vga_clk = 1'b1;
        vga_blank_n = blank;
        vga_hs = hs;
        vga_vs = vs;
        {vga_r, vga_g, vga_b} = c;
        rst_now = 1'b0;
        if (rst_armed && blank && x == rst_x && y == rst_y) begin
            rst_armed = 1'b0;
            rst_now = 1'b1;
            reset = 1'b1;
            pix_q.delete();
            frm_q.delete();
            m_phase = 0;
            m_fc = 0;
        end
        if (blank && m_phase == 2) begin
            pe = '{due: cyc + 2, x: 11'((x > 2047) ? 2047 : x), y: 11'(y), c: c};
            pix_q.push_back(pe);
        end
        if (vs_fall) model_frame_end(ok);
        tick();
        if (rst_now) begin
            check("rst_locked", 128'(locked), 128'(0));
            check("rst_pixelX", 128'(pixelX), 128'(0));
            check("rst_pixelY", 128'(pixelY), 128'(0));
            reset = 1'b0;
        end
        vga_clk = 1'b0;
    endtask

    task automatic set_lens(input int n, input int bad_line, input int bad_len);
        lens.delete();
        for (int j = 0; j < n; j++) lens.push_back((j == bad_line) ? bad_len : int'(H));
    endtask

    // One frame: lens[] active lines, hblank per line, then vblank with vs low.
    task automatic gen_frame(input bit tight, input bit mark);
        bit ok;
        int n;
        int vs_left;
        n = lens.size();
        ok = (n == int'(V));
        foreach (lens[j]) if (((lens[j] > 2047) ? 2047 : lens[j]) != int'(H)) ok = 1'b0;
        vs_left = 0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < lens[j]; i++) begin
                logic [23:0] c;
                c = 24'($urandom);
                if (mark && j == n - 1 && i == lens[j] - 1) c = 24'hFF0000;
                drive_pixel(1'b1, 1'b1, 1'b1, c, i, j, 1'b0, ok);
            end
            for (int k = 0; k < int'(HBL); k++) begin
                bit fall;
                fall = tight && (j == n - 1) && (k == 0);
                if (fall) vs_left = 2 * LW;
                drive_pixel(1'b0, !(k >= 1 && k <= 3), (vs_left == 0), 24'h0, 0, 0, fall, ok);
                if (vs_left > 0) vs_left--;
            end
        end
        for (int k = 0; k < int'(VBL * LW); k++) begin
            bit fall;
            fall = !tight && (k == 0);
            if (fall) vs_left = 2 * LW;
            drive_pixel(1'b0, !((k % LW) >= 1 && (k % LW) <= 3), (vs_left == 0), 24'h0, 0, 0, fall, ok);
            if (vs_left > 0) vs_left--;
        end
    endtask

    initial begin
        reset = 1'b1;
        vga_clk = 1'b0;
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        vga_blank_n = 1'b0;
        {vga_r, vga_g, vga_b} = 24'h0;
        repeat (3) tick();
        check("reset_outputs", 128'({pixel_valid, frame_start, locked, lock_err}), 128'(0));
        check("reset_frame_count", 128'(frame_count), 128'(0));
        check("reset_pixel", 128'({pixelX, pixelY, rgb}), 128'(0));
        reset = 1'b0;

        set_lens(V, -1, 0);
        gen_frame(1'b0, 1'b0);
        check("f1_not_locked", 128'(locked), 128'(0));
        gen_frame(1'b0, 1'b0);
        check("f2_locked", 128'(locked), 128'(1));
        gen_frame(1'b0, 1'b0);
        check("f3_pixels", 128'(last_frame_pix), 128'(H * V));
        check("f3_frame_count", 128'(frame_count), 128'(1));
        gen_frame(1'b0, 1'b1);

        set_lens(V, 3, H - 1);
        gen_frame(1'b0, 1'b0);
        check("short_line_unlock", 128'(locked), 128'(0));
        set_lens(V, -1, 0);
        gen_frame(1'b0, 1'b0);
        gen_frame(1'b0, 1'b0);
        check("relock", 128'(locked), 128'(1));
        gen_frame(1'b0, 1'b0);

        set_lens(V + 1, -1, 0);
        gen_frame(1'b0, 1'b0);
        set_lens(V, -1, 0);
        gen_frame(1'b0, 1'b0);
        set_lens(V + 1, -1, 0);
        gen_frame(1'b0, 1'b0);
        check("tall_in_measure", 128'(locked), 128'(0));

        set_lens(V, -1, 0);
        gen_frame(1'b1, 1'b0);
        gen_frame(1'b1, 1'b0);
        check("tight_locked", 128'(locked), 128'(1));
        gen_frame(1'b1, 1'b0);

        rst_armed = 1'b1;
        rst_x = H / 2;
        rst_y = V / 2;
        gen_frame(1'b0, 1'b0);
        check("post_reset_measure", 128'(locked), 128'(0));
        gen_frame(1'b0, 1'b0);
        check("post_reset_relock", 128'(locked), 128'(1));
        gen_frame(1'b0, 1'b0);

        set_lens(V, 2, 3000);
        gen_frame(1'b0, 1'b0);
        check("sat_line_unlock", 128'(locked), 128'(0));

        for (int f = 0; f < 6; f++) begin
            int n;
            n = ($urandom_range(0, 5) == 0) ? int'(V) + 1 : int'(V);
            lens.delete();
            for (int j = 0; j < n; j++)
                lens.push_back(($urandom_range(0, 11) == 0) ? int'(H) - 1 : int'(H));
            gen_frame(1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) tick();
        check("pix_queue_drained", 128'(pix_q.size()), 128'(0));
        check("frm_queue_drained", 128'(frm_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
